// File: rtl/axis_demux_pkg.sv
// Shared types and helpers for the AXI4-S demultiplexer.
//   route_state_e : packet routing state (SOP = waiting for a head beat,
//                   BODY = forwarding/discarding the rest of a packet)
//   sel_width()   : channel-select width, never less than one bit
package axis_demux_pkg;

  typedef enum logic {
    ST_SOP  = 1'b0,
    ST_BODY = 1'b1
  } route_state_e;

  function automatic int sel_width(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/axis_demux_if.sv
// AXI4-Stream bundle used throughout the AFU datapath.
//   source : the side that drives tvalid/payload and receives tready
//   sink   : the side that receives tvalid/payload and drives tready
// tkeep is TDATA_WIDTH/8 bits wide.
interface ofs_axis_if #(
  parameter int TDATA_WIDTH = 8,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1
);
  logic                     tvalid;
  logic                     tready;
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic                     tlast;
  logic [TID_WIDTH-1:0]     tid;
  logic [TDEST_WIDTH-1:0]   tdest;
  logic [TUSER_WIDTH-1:0]   tuser;

  modport source (output tvalid, tdata, tkeep, tlast, tid, tdest, tuser,
                  input  tready);
  modport sink   (input  tvalid, tdata, tkeep, tlast, tid, tdest, tuser,
                  output tready);
endinterface

// File: rtl/ofs_fim_axis_register.sv
// Fully registered AXI4-S pipeline stage (head register + skid register).
// tready toward the upstream is a flop, so no combinational path crosses
// this stage in either direction.
//   clk, rst_n : clock, synchronous active-low reset
//   s_if       : upstream stream (sink side)
//   m_if       : downstream stream (source side)
module ofs_fim_axis_register #(
  parameter int TDATA_WIDTH = 8,
  parameter int TID_WIDTH   = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  ofs_axis_if.sink     s_if,
  ofs_axis_if.source   m_if
);
  localparam int PW = TDATA_WIDTH + TDATA_WIDTH/8 + 1 + TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;

  logic [PW-1:0] in_pl, head_pl, skid_pl;
  logic          head_valid, skid_valid, in_ready_q;
  logic          in_fire, head_free;

  assign in_pl = {s_if.tdata, s_if.tkeep, s_if.tlast, s_if.tid, s_if.tdest, s_if.tuser};
  assign {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tid, m_if.tdest, m_if.tuser} = head_pl;
  assign m_if.tvalid = head_valid;
  assign s_if.tready = in_ready_q;

  assign in_fire   = s_if.tvalid & in_ready_q;
  assign head_free = ~head_valid | m_if.tready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      if (head_free) begin
        if (skid_valid) begin
          head_pl    <= skid_pl;
          head_valid <= 1'b1;
          skid_valid <= 1'b0;
        end else begin
          head_valid <= in_fire;
          if (in_fire) head_pl <= in_pl;
        end
      end else if (in_fire) begin
        skid_pl    <= in_pl;
        skid_valid <= 1'b1;
      end
      // Ready next cycle exactly when the skid slot will be empty.
      in_ready_q <= head_free | (~in_fire & ~skid_valid);
    end
  end

endmodule

// File: rtl/axis_demux.sv
// 1:NUM_CH AXI4-S packet demultiplexer. The first beat's tdest picks the
// output channel for the whole packet; packets whose tdest is out of range
// are drained at full rate and counted in a saturating drop counter.
//   clk, rst_n : clock, synchronous active-low reset
//   sink       : input stream
//   source[]   : one output stream per channel
//   drop_cnt   : number of dropped packets, saturating
module axis_demux
  import axis_demux_pkg::*;
#(
  parameter int NUM_CH         = 1,
  parameter int TDATA_WIDTH    = 8,
  parameter int TID_WIDTH      = 1,
  parameter int TDEST_WIDTH    = 1,
  parameter int TUSER_WIDTH    = 1,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  ofs_axis_if.sink                  sink,
  ofs_axis_if.source                source [NUM_CH],
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);
  localparam int SEL_WIDTH = sel_width(NUM_CH);
  localparam int PW = TDATA_WIDTH + TDATA_WIDTH/8 + 1 + TID_WIDTH + TDEST_WIDTH + TUSER_WIDTH;

  ofs_axis_if #(
    .TDATA_WIDTH(TDATA_WIDTH), .TID_WIDTH(TID_WIDTH),
    .TDEST_WIDTH(TDEST_WIDTH), .TUSER_WIDTH(TUSER_WIDTH)
  ) head ();

  ofs_fim_axis_register #(
    .TDATA_WIDTH(TDATA_WIDTH), .TID_WIDTH(TID_WIDTH),
    .TDEST_WIDTH(TDEST_WIDTH), .TUSER_WIDTH(TUSER_WIDTH)
  ) u_in_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .s_if (sink),
    .m_if (head)
  );

  route_state_e          state;
  logic [SEL_WIDTH-1:0]  sel_q, cur_sel;
  logic                  drop_q, cur_drop, head_in_range;
  logic                  tgt_ready, head_accept;
  logic [NUM_CH-1:0]     ch_ready, ch_load;
  logic [PW-1:0]         head_pl;

  assign head_pl = {head.tdata, head.tkeep, head.tlast, head.tid, head.tdest, head.tuser};

  // Full tdest is compared, so upper bits beyond SEL_WIDTH also force a drop.
  assign head_in_range = int'(head.tdest) < NUM_CH;
  assign cur_sel  = (state == ST_SOP) ? head.tdest[SEL_WIDTH-1:0] : sel_q;
  assign cur_drop = (state == ST_SOP) ? ~head_in_range : drop_q;

  always_comb begin
    tgt_ready = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(cur_sel) == i) tgt_ready = ch_ready[i];
    end
  end

  // Dropped traffic never waits on any output channel.
  assign head.tready = cur_drop | tgt_ready;
  assign head_accept = head.tvalid & head.tready;

  always_comb begin
    ch_load = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_load[i] = head_accept & ~cur_drop & (int'(cur_sel) == i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_SOP;
      sel_q    <= '0;
      drop_q   <= 1'b0;
      drop_cnt <= '0;
    end else if (head_accept) begin
      if (state == ST_SOP) begin
        sel_q  <= cur_sel;
        drop_q <= ~head_in_range;
        if (~head_in_range && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
      end
      state <= head.tlast ? ST_SOP : ST_BODY;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic          out_valid;
    logic [PW-1:0] out_pl;

    assign ch_ready[i] = ~out_valid | source[i].tready;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        out_valid <= 1'b0;
      end else if (ch_ready[i]) begin
        out_valid <= ch_load[i];
        if (ch_load[i]) out_pl <= head_pl;
      end
    end

    assign source[i].tvalid = out_valid;
    assign {source[i].tdata, source[i].tkeep, source[i].tlast,
            source[i].tid, source[i].tdest, source[i].tuser} = out_pl;
  end

endmodule

// File: tb/tb_axis_demux.sv
module tb_axis_demux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // ---------------- DUT A: 4 channels, wide counter ----------------
  ofs_axis_if #(.TDATA_WIDTH(8), .TID_WIDTH(1), .TDEST_WIDTH(2), .TUSER_WIDTH(1)) snk_a ();
  ofs_axis_if #(.TDATA_WIDTH(8), .TID_WIDTH(1), .TDEST_WIDTH(2), .TUSER_WIDTH(1)) src_a [4] ();
  logic [15:0] drop_a;

  axis_demux #(.NUM_CH(4), .TDATA_WIDTH(8), .TID_WIDTH(1), .TDEST_WIDTH(2),
               .TUSER_WIDTH(1), .DROP_CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .sink(snk_a), .source(src_a), .drop_cnt(drop_a));

  // ---------------- DUT B: 3 channels, 2-bit counter ----------------
  ofs_axis_if #(.TDATA_WIDTH(8), .TID_WIDTH(1), .TDEST_WIDTH(2), .TUSER_WIDTH(1)) snk_b ();
  ofs_axis_if #(.TDATA_WIDTH(8), .TID_WIDTH(1), .TDEST_WIDTH(2), .TUSER_WIDTH(1)) src_b [3] ();
  logic [1:0] drop_b;

  axis_demux #(.NUM_CH(3), .TDATA_WIDTH(8), .TID_WIDTH(1), .TDEST_WIDTH(2),
               .TUSER_WIDTH(1), .DROP_CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .sink(snk_b), .source(src_b), .drop_cnt(drop_b));

  // ---------------- drivers ----------------
  logic       a_valid = 0, a_last = 0, b_valid = 0, b_last = 0;
  logic [7:0] a_data = 0, b_data = 0;
  logic [1:0] a_dest = 0, b_dest = 0;
  logic [3:0] rdy_a = 4'hF;

  assign snk_a.tvalid = a_valid;  assign snk_a.tdata = a_data;  assign snk_a.tkeep = 1'b1;
  assign snk_a.tlast  = a_last;   assign snk_a.tdest = a_dest;
  assign snk_a.tid    = a_data[1]; assign snk_a.tuser = a_data[0];
  assign snk_b.tvalid = b_valid;  assign snk_b.tdata = b_data;  assign snk_b.tkeep = 1'b1;
  assign snk_b.tlast  = b_last;   assign snk_b.tdest = b_dest;
  assign snk_b.tid    = b_data[1]; assign snk_b.tuser = b_data[0];

  // payload seen at an output: {tdata, tlast, tdest, tid, tuser}
  logic [3:0]  mv_a;
  logic [12:0] mpl_a [4];
  logic [2:0]  mv_b;

  for (genvar g = 0; g < 4; g++) begin : g_a
    assign mv_a[g]  = src_a[g].tvalid;
    assign mpl_a[g] = {src_a[g].tdata, src_a[g].tlast, src_a[g].tdest, src_a[g].tid, src_a[g].tuser};
    assign src_a[g].tready = rdy_a[g];
  end
  for (genvar g = 0; g < 3; g++) begin : g_b
    assign mv_b[g] = src_b[g].tvalid;
    assign src_b[g].tready = 1'b1;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [12:0] pl;
    int          acc;
  } exp_t;

  exp_t exp_q [4][$];
  exp_t mon_e;
  bit   m_sop = 1;
  int   m_sel = 0;
  bit   lat_chk = 0;
  bit   b_phase = 0;
  bit   stall_q [4];
  logic [12:0] stall_pl [4];

  function automatic logic [12:0] mk(input logic [7:0] d, input logic l, input logic [1:0] dst);
    return {d, l, dst, d[1], d[0]};
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (stall_q[i]) begin
          checks++;
          if (!mv_a[i] || mpl_a[i] != stall_pl[i]) begin
            errors++;
            $display("FAIL hold ch%0d: valid=%0b pl=%h, required valid=1 pl=%h",
                     i, mv_a[i], mpl_a[i], stall_pl[i]);
          end
        end
        if (mv_a[i] && rdy_a[i]) begin
          checks++;
          if (exp_q[i].size() == 0) begin
            errors++;
            $display("FAIL unexpected ch%0d: got pl=%h, required no beat", i, mpl_a[i]);
          end else begin
            mon_e = exp_q[i].pop_front();
            if (mpl_a[i] != mon_e.pl) begin
              errors++;
              $display("FAIL beat ch%0d: got pl=%h, required %h", i, mpl_a[i], mon_e.pl);
            end
            if (lat_chk) begin
              checks++;
              if (cyc != mon_e.acc + 1) begin
                errors++;
                $display("FAIL latency ch%0d: out edge %0d, required %0d", i, cyc + 1, mon_e.acc + 2);
              end
            end
          end
        end
        stall_q[i]  = mv_a[i] && !rdy_a[i];
        stall_pl[i] = mpl_a[i];
      end
      if (b_phase) begin
        checks++;
        if (mv_b != 3'b000) begin
          errors++;
          $display("FAIL b_valid: source tvalid=%b, required 000", mv_b);
        end
        if (b_valid) begin
          checks++;
          if (!snk_b.tready) begin
            errors++;
            $display("FAIL b_ready: sink.tready=0 while dropping, required 1");
          end
        end
      end
    end else begin
      for (int i = 0; i < 4; i++) stall_q[i] = 0;
    end
  end

  // ---------------- tasks ----------------
  task automatic send(input bit b, input logic [7:0] d, input logic l, input logic [1:0] dst);
    bit ok;
    int n;
    if (b) begin b_valid = 1; b_data = d; b_last = l; b_dest = dst; end
    else   begin a_valid = 1; a_data = d; a_last = l; a_dest = dst; end
    ok = 0;
    n  = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = b ? snk_b.tready : snk_a.tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL accept: sink.tready=0 for %0d cycles, required 1", n);
    end else if (!b) begin
      if (m_sop) m_sel = int'(dst);
      exp_q[m_sel].push_back('{pl: mk(d, l, dst), acc: cyc});
      m_sop = l;
    end
  endtask

  task automatic drain_check(input string name);
    int left;
    a_valid = 0;
    repeat (8) @(posedge clk);
    #1;
    left = 0;
    for (int i = 0; i < 4; i++) left += exp_q[i].size();
    checks++;
    if (left != 0) begin
      errors++;
      $display("FAIL %s drain: %0d beats missing, required 0", name, left);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 0;
    a_valid = 0;
    b_valid = 0;
    for (int i = 0; i < 4; i++) exp_q[i].delete();
    m_sop = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (mv_a != 4'b0 || mv_b != 3'b0 || snk_a.tready || snk_b.tready || drop_a != 0 || drop_b != 0) begin
      errors++;
      $display("FAIL reset: valid_a=%b valid_b=%b rdy_a=%0b rdy_b=%0b drop_a=%0d drop_b=%0d, required all 0",
               mv_a, mv_b, snk_a.tready, snk_b.tready, drop_a, drop_b);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (!snk_a.tready || !snk_b.tready) begin
      errors++;
      $display("FAIL release: sink.tready a=%0b b=%0b, required 1 1", snk_a.tready, snk_b.tready);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int  drop_exp [5] = '{1, 2, 3, 3, 3};
  bit  saw_stall;

  initial begin
    do_reset();

    // back-to-back: 3 beats to ch2 then 1 beat to ch0, exact latency
    lat_chk = 1;
    send(0, 8'h21, 0, 2'd2);
    send(0, 8'h22, 0, 2'd2);
    send(0, 8'h23, 1, 2'd2);
    send(0, 8'h01, 1, 2'd0);
    drain_check("b2b");

    // tdest changes mid-packet: stays on ch1, sideband passes through
    send(0, 8'h31, 0, 2'd1);
    send(0, 8'h32, 0, 2'd3);
    send(0, 8'h33, 0, 2'd3);
    send(0, 8'h34, 1, 2'd3);
    drain_check("tdest_change");
    lat_chk = 0;

    // backpressure on ch1 for 10 cycles
    saw_stall = 0;
    fork
      begin
        for (int j = 0; j < 8; j++) send(0, 8'h40 + 8'(j), (j == 7), 2'd1);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        rdy_a[1] = 0;
        repeat (10) begin
          @(negedge clk);
          if (!snk_a.tready) saw_stall = 1;
          @(posedge clk);
        end
        #1;
        rdy_a[1] = 1;
      end
    join
    drain_check("backpressure");
    checks++;
    if (!saw_stall) begin
      errors++;
      $display("FAIL skid_full: sink.tready never 0 during stall, required 0");
    end

    // reset in the middle of a packet to ch0, then a packet to ch3
    send(0, 8'h51, 0, 2'd0);
    send(0, 8'h52, 0, 2'd0);
    do_reset();
    send(0, 8'h61, 0, 2'd3);
    send(0, 8'h62, 1, 2'd3);
    drain_check("post_reset");
    checks++;
    if (drop_a != 0) begin
      errors++;
      $display("FAIL drop_a: got %0d, required 0", drop_a);
    end

    // NUM_CH=3: tdest=3 dropped, body tdest ignored, counter saturates
    b_phase = 1;
    for (int p = 0; p < 5; p++) begin
      if (p == 0) begin
        send(1, 8'h70, 0, 2'd3);
        send(1, 8'h71, 1, 2'd0);
      end else begin
        send(1, 8'h80 + 8'(p), 1, 2'd3);
      end
      b_valid = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (int'(drop_b) != drop_exp[p]) begin
        errors++;
        $display("FAIL drop_cnt pkt%0d: got %0d, required %0d", p, drop_b, drop_exp[p]);
      end
      @(posedge clk);
      #1;
    end
    b_phase = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, required finish");
    $fatal(1, "timeout");
  end

endmodule
